// File: rtl/bus_arbiter.sv
// Two-master bus arbiter and address decoder: main memory, video memory, status register.
// Define BUS_ARB_RR_EN for round-robin arbitration; default is fixed priority (master 0 first).
`timescale 1ns/1ps
module bus_arbiter #(
    parameter int MEM_WAIT = 6,
    parameter int VM_AW    = 4
) (
    input  logic             clk_50mhz,
    input  logic             rst_n,
    input  logic             m0_req,
    input  logic [1:0]       m0_we,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    input  logic             m1_req,
    input  logic [1:0]       m1_we,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    output logic             m0_ack,
    output logic             m1_ack,
    output logic [31:0]      rdata,
    output logic             mem_read,
    output logic [1:0]       mem_write,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             vm_write,
    output logic [VM_AW-1:0] vm_addr,
    output logic [31:0]      vm_wdata,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {RG_MEM, RG_VM, RG_STAT} region_t;

    state_t            state_q;
    region_t           rg_q, sel_rg;
    logic              id_q, last_q, win;
    logic [1:0]        we_q, sel_we;
    logic [3:0]        cnt_q;
    logic [15:0]       txn_q;
    logic [31:0]       sel_addr, sel_wdata, rdata_q, mem_addr_q, mem_wdata_q, vm_wdata_q;
    logic [VM_AW-1:0]  vm_addr_q;
    logic              m0_ack_q, m1_ack_q, mem_read_q, vm_write_q, busy_q;
    logic [1:0]        mem_write_q;

    // win is only meaningful when at least one master requests
    always_comb begin
`ifdef BUS_ARB_RR_EN
        win = m0_req ? (m1_req ? ~last_q : 1'b0) : 1'b1;
`else
        win = ~m0_req;
`endif
        sel_we    = win ? m1_we    : m0_we;
        sel_addr  = win ? m1_addr  : m0_addr;
        sel_wdata = win ? m1_wdata : m0_wdata;
        case (sel_addr[31:28])
            4'hA:    sel_rg = RG_VM;
            4'hB:    sel_rg = RG_STAT;
            default: sel_rg = RG_MEM;
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rg_q        <= RG_MEM;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 2'd0;
            cnt_q       <= 4'd0;
            txn_q       <= 16'd0;
            rdata_q     <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            vm_addr_q   <= '0;
            vm_wdata_q  <= 32'd0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 2'd0;
            vm_write_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            case (state_q)
                IDLE: if (m0_req || m1_req) begin
                    id_q    <= win;
                    last_q  <= win;
                    we_q    <= sel_we;
                    rg_q    <= sel_rg;
                    cnt_q   <= 4'(MEM_WAIT);
                    state_q <= ACCESS;
                    busy_q  <= 1'b1;
                    // strobes are registered, so they are raised on the grant edge
                    if (sel_rg == RG_MEM) begin
                        mem_read_q  <= (sel_we == 2'd0);
                        mem_write_q <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                    end
                    if (sel_rg == RG_VM) begin
                        vm_write_q <= (sel_we != 2'd0);
                        vm_addr_q  <= sel_addr[VM_AW-1:0];
                        vm_wdata_q <= sel_wdata;
                    end
                end
                ACCESS: begin
                    case (rg_q)
                        RG_MEM: if (cnt_q == 4'd0) begin
                            mem_read_q  <= 1'b0;
                            mem_write_q <= 2'd0;
                            if (we_q == 2'd0) rdata_q <= mem_rdata;
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                        RG_VM: begin
                            vm_write_q <= 1'b0;
                            if (we_q == 2'd0) rdata_q <= 32'd0;
                            state_q <= DONE;
                        end
                        default: begin
                            if (we_q == 2'd0) rdata_q <= {16'd0, txn_q};
                            state_q <= DONE;
                        end
                    endcase
                end
                DONE: begin
                    m0_ack_q <= ~id_q;
                    m1_ack_q <= id_q;
                    txn_q    <= txn_q + 16'd1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign rdata     = rdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign vm_write  = vm_write_q;
    assign vm_addr   = vm_addr_q;
    assign vm_wdata  = vm_wdata_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: transaction-timing reference model, decoupled ack monitor.
`timescale 1ns/1ps
module tb_bus_arbiter;
    localparam int MW = 6;
    localparam int AW = 4;
    localparam logic [31:0] RDK = 32'hDEADBEFF;
`ifdef BUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk_50mhz = 1'b0, rst_n = 1'b0;
    logic m0_req = 1'b0, m1_req = 1'b0;
    logic [1:0] m0_we = 2'd0, m1_we = 2'd0;
    logic [31:0] m0_addr = 32'd0, m1_addr = 32'd0, m0_wdata = 32'd0, m1_wdata = 32'd0;
    logic m0_ack, m1_ack, mem_read, vm_write, busy;
    logic [1:0] mem_write;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata, vm_wdata;
    logic [AW-1:0] vm_addr;

    // memory returns a value derived from its address so the read path is checked end to end
    assign mem_rdata = mem_addr ^ RDK;

    bus_arbiter #(.MEM_WAIT(MW), .VM_AW(AW)) dut (
        .clk_50mhz(clk_50mhz), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .rdata(rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .vm_write(vm_write), .vm_addr(vm_addr), .vm_wdata(vm_wdata), .busy(busy)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    typedef struct {int m; bit rd; logic [31:0] data; int cyc;} exp_t;
    exp_t sbq[$];
    int total = 0, bad = 0, cyc = 0;

    // reference model state: the current transaction as seen at transaction level
    int free_at = 0, last = 1, cnt = 0, k = -100, acc_end = -100, busy_end = -100, rg = 0;
    logic [1:0]  twe = 2'd0;
    logic [31:0] tad = 32'd0, twd = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // model: grant decision and latency per sampling edge
    initial forever begin
        @(posedge clk_50mhz or negedge rst_n);
        if (!rst_n) begin
            free_at = 0; last = 1; cnt = 0; k = -100; acc_end = -100; busy_end = -100;
            sbq.delete();
        end else begin
            cyc++;
            if (cyc >= free_at && (m0_req || m1_req)) begin
                int w, lat;
                exp_t e;
                if (m0_req && m1_req) w = RR ? 1 - last : 0;
                else w = m0_req ? 0 : 1;
                last = w;
                twe = w ? m1_we : m0_we;
                tad = w ? m1_addr : m0_addr;
                twd = w ? m1_wdata : m0_wdata;
                rg  = (tad[31:28] == 4'hA) ? 1 : (tad[31:28] == 4'hB) ? 2 : 0;
                lat = (rg == 0) ? MW + 2 : 2;
                k = cyc; acc_end = cyc + lat - 2; busy_end = cyc + lat - 1; free_at = cyc + lat + 1;
                e.m = w; e.rd = (twe == 2'd0); e.cyc = cyc + lat;
                e.data = (rg == 0) ? (tad ^ RDK) : (rg == 1) ? 32'd0 : {16'd0, cnt[15:0]};
                sbq.push_back(e);
                cnt++;
            end
        end
    end

    // monitor: strobes every cycle, acks against the scoreboard
    initial forever begin
        @(negedge clk_50mhz);
        if (rst_n) begin
            bit ia, ib;
            exp_t e;
            ia = (cyc >= k) && (cyc <= acc_end);
            ib = (cyc >= k) && (cyc <= busy_end);
            chk("busy", 32'(busy), 32'(ib));
            chk("mem_read", 32'(mem_read), 32'(ia && rg == 0 && twe == 2'd0));
            chk("mem_write", 32'(mem_write), (ia && rg == 0) ? 32'(twe) : 32'd0);
            chk("vm_write", 32'(vm_write), 32'(ia && rg == 1 && twe != 2'd0));
            if (ia && rg == 0) begin
                chk("mem_addr", mem_addr, tad);
                chk("mem_wdata", mem_wdata, twd);
            end
            if (ia && rg == 1 && twe != 2'd0) begin
                chk("vm_addr", 32'(vm_addr), 32'(tad[AW-1:0]));
                chk("vm_wdata", vm_wdata, twd);
            end
            if (m0_ack && m1_ack) chk("dual_ack", 32'(m1_ack), 32'd0);
            else if (m0_ack || m1_ack) begin
                if (sbq.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
                else begin
                    e = sbq.pop_front();
                    chk("ack_master", m1_ack ? 32'd1 : 32'd0, 32'(e.m));
                    chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                    if (e.rd) chk("rdata", rdata, e.data);
                end
            end
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                chk("missing_ack", 32'(cyc), 32'(sbq[0].cyc));
                void'(sbq.pop_front());
            end
        end
    end

    task automatic do_txn(input int m, input logic [1:0] we, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd);
        bit got = 0;
        if (m == 0) begin m0_we = we; m0_addr = a; m0_wdata = wd; m0_req = 1'b1; end
        else        begin m1_we = we; m1_addr = a; m1_wdata = wd; m1_req = 1'b1; end
        rd = 32'd0;
        for (int t = 0; t < 5000 && !got; t++) begin
            @(negedge clk_50mhz);
            if ((m == 0) ? m0_ack : m1_ack) begin
                got = 1; rd = rdata;
                if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
            end
        end
        if (!got) begin
            chk("ack_timeout", 32'(m), 32'hFFFF_FFFF);
            if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
        end
    endtask

    task automatic run_master(input int m, input int n, input int maxgap);
        logic [31:0] a, rd;
        int sel;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, maxgap)) @(negedge clk_50mhz);
            sel = $urandom_range(0, 3);
            if (sel < 2)       a = {4'($urandom_range(0, 9)), 28'($urandom)};
            else if (sel == 2) a = {4'hA, 28'($urandom)};
            else               a = {4'hB, 28'($urandom)};
            do_txn(m, 2'($urandom_range(0, 3)), a, $urandom, rd);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        repeat (3) @(negedge clk_50mhz);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_vm_wdata", vm_wdata, 32'd0);
        chk("rst_acks", 32'({m0_ack, m1_ack, mem_read, vm_write}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_50mhz);

        do_txn(0, 2'd0, 32'h0000_0010, 32'd0, rd);
        chk("mem_read_data", rd, 32'hDEADBEEF);
        do_txn(1, 2'd1, 32'hA000_0003, 32'h1234_5678, rd);
        do_txn(0, 2'd2, 32'h0000_0200, 32'hCAFE_0001, rd);
        do_txn(1, 2'd0, 32'hA000_0007, 32'd0, rd);
        chk("vm_read_zero", rd, 32'd0);
        do_txn(0, 2'd3, 32'h3000_0000, 32'h5555_AAAA, rd);
        do_txn(0, 2'd0, 32'hB000_0000, 32'd0, rd);
        chk("status_after5", rd, 32'd5);
        do_txn(1, 2'd1, 32'hB000_0000, 32'hFFFF_FFFF, rd);
        do_txn(0, 2'd0, 32'hB000_0004, 32'd0, rd);
        chk("status_after7", rd, 32'd7);

        fork
            run_master(0, 4, 0);
            run_master(1, 4, 0);
        join
        fork
            run_master(0, 40, 3);
            run_master(1, 40, 3);
        join

        // reset during the third ACCESS cycle of a memory write
        @(negedge clk_50mhz);
        m0_we = 2'd1; m0_addr = 32'h0000_0100; m0_wdata = 32'h0BAD_F00D; m0_req = 1'b1;
        repeat (3) @(posedge clk_50mhz);
        #3;
        chk("pre_rst_mem_write", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_write", 32'(mem_write), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        m0_req = 1'b0;
        repeat (2) @(negedge clk_50mhz);
        chk("mid_rst_ack", 32'({m0_ack, m1_ack}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_50mhz);
        do_txn(0, 2'd0, 32'hB000_0000, 32'd0, rd);
        chk("status_after_rst", rd, 32'd0);

        repeat (5) @(negedge clk_50mhz);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter and address decoder for the shared 32-bit system bus. Sequences every access from the CPU (master 0) and a secondary master (master 1, e.g. keyboard scan-code writer) onto main memory, video memory or a read-only status register. Lives in the top level between the masters and the memory/VGA instances, all on `clk_50mhz`.

## Interface
- `MEM_WAIT`, 6: extra cycles main memory strobes are held (0–15)
- `VM_AW`, 4: video-memory address width
- `clk_50mhz`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `m0_req`, `m1_req`  in  1  request, held until ack
- `m0_we`, `m1_we`  in  2  write code; 0 = read, nonzero = write (forwarded unchanged)
- `m0_addr`, `m1_addr`  in  32  byte address
- `m0_wdata`, `m1_wdata`  in  32  write data
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse
- `rdata`  out  32  read data, valid in the ack cycle
- `mem_read`  out  1  main-memory read strobe
- `mem_write`  out  2  main-memory write code
- `mem_addr`, `mem_wdata`  out  32  main-memory address/data
- `mem_rdata`  in  32  main-memory read data
- `vm_write`  out  1  video-memory write strobe
- `vm_addr`  out  VM_AW  video-memory address (`addr[VM_AW-1:0]`)
- `vm_wdata`  out  32  video-memory data
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- Decode on latched `addr[31:28]`: `4'hA` = video memory; `4'hB` = status; anything else = main memory.
- States: IDLE, ACCESS, DONE.
- IDLE: if any req, choose winner, latch its we/addr/wdata and master id, load wait counter, go to ACCESS. No req: stay.
- ACCESS, main memory: `mem_read` = (we==0), `mem_write` = we, address/data driven from latch; held MEM_WAIT+1 cycles, counter decrements to 0, then DONE. `mem_rdata` captured into `rdata` on the last ACCESS cycle.
- ACCESS, video: `vm_write` high exactly one cycle if we≠0; reads return 0. Then DONE.
- ACCESS, status: one cycle; reads return `{16'b0, txn_count}`; writes are ignored but still acked.
- DONE: pulse ack of the latched master, increment `txn_count` (16-bit, wraps 0xFFFF→0), go to IDLE.
- A master still holding req in the cycle after its ack starts a new transaction (no implicit hold-off).
- Request inputs are ignored outside IDLE; the latched copy is used for the whole transaction.
- Outside ACCESS all strobes are 0 and `mem_addr`/`mem_wdata`/`vm_*` hold their last values.

## Timing
- Reset (async, immediate): state IDLE, all acks/strobes 0, `rdata` 0, `mem_addr`/`mem_wdata`/`vm_addr`/`vm_wdata` 0, `txn_count` 0, `busy` 0, last-grant = master 1 (so master 0 wins first).
- Req sampled in IDLE at edge k: main-memory ack in cycle k+MEM_WAIT+2; video/status ack in cycle k+2.
- Back-to-back throughput: one transaction per MEM_WAIT+3 cycles (memory), 3 cycles (video/status).
- Reset asserted mid-transaction: transaction abandoned, no ack, strobes drop asynchronously; requester must reissue.
- MEM_WAIT=0: memory strobes held exactly one cycle.

## Configuration
- `BUS_ARB_RR_EN` defined: round-robin — when both request in IDLE, grant the master not granted last; last-grant updates on every grant.
- Not defined: fixed priority — master 0 always wins simultaneous requests; master 1 is served only when `m0_req` is low in IDLE.

## Test plan
- Reset, then m0 reads 0x0000_0010 with MEM_WAIT=6, `mem_rdata`=0xDEADBEEF -> `mem_read` high 7 cycles, `m0_ack` and `rdata`=0xDEADBEEF 8 cycles after sample.
- m1 writes 0x1234_5678 to 0xA000_0003, we=1 -> `vm_write` one cycle with `vm_addr`=3, `vm_wdata`=0x12345678; `mem_*` strobes stay 0; ack 2 cycles after sample.
- Both masters request continuously for 4 transactions -> RR build: grants 0,1,0,1; non-RR build: 0,0,0,0 and `m1_ack` never pulses.
- After 5 completed transactions, m0 reads 0xB000_0000 -> `rdata`=0x0000_0005; a write to 0xB000_0000 acks and leaves the count path unaffected except the increment.
- `rst_n` low during the 3rd ACCESS cycle of a memory write -> `mem_write` 0 immediately, no ack, `busy` 0, `txn_count` 0.
